modulation_segment_buffer: RTL

- Parametrised, multi-segment modulation sample store. Successor to the single-buffer modulation memory.
- The CPU-side bridge, already synchronised to CLK, writes packed sample words into an inactive segment. The modulation sampler reads one sample per request from the active segment.
- Segment swaps happen immediately or at the next cycle boundary (index 0). This gives glitch-free pattern changes.
- Per-segment cycle length is held here. Out-of-range reads are flagged and return zero.

---
 rtl/mod_seg_pkg.sv | 18 +
 rtl/modulation_segment_buffer_if.sv | 40 ++++
 rtl/mod_seg_ram.sv | 25 ++
 rtl/modulation_segment_buffer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mod_seg_pkg.sv
// Shared types and helpers for the segmented modulation sample store.
package mod_seg_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    function automatic int seg_w(input int num_seg);
        return (num_seg > 2) ? $clog2(num_seg) : 1;
    endfunction

    // Every segment starts out spanning its full depth.
    function automatic logic [31:0] cyc_last_rst(input int addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/modulation_segment_buffer_if.sv
// Write, cycle-length, swap and read-request/response signals of the segment buffer.
interface modulation_segment_buffer_if import mod_seg_pkg::*; #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 15,
    parameter int NUM_SEG = 2
);
    localparam int SEG_W = seg_w(NUM_SEG);

    logic                wr_en;
    logic [SEG_W-1:0]    wr_seg;
    logic [ADDR_W-2:0]   wr_addr;
    logic [2*DATA_W-1:0] wr_dat;
    logic                wr_err;
    logic                cyc_we;
    logic [SEG_W-1:0]    cyc_seg;
    logic [ADDR_W-1:0]   cyc_last;
    logic                swap_req;
    logic [SEG_W-1:0]    swap_seg;
    logic                swap_imm;
    logic                rd_vld;
    logic [ADDR_W-1:0]   rd_idx;
    logic                m_vld;
    logic [DATA_W-1:0]   m_dat;
    logic                m_oor;
    logic [SEG_W-1:0]    active_seg;
    logic                swap_pending;

    modport master (
        output wr_en, wr_seg, wr_addr, wr_dat, cyc_we, cyc_seg, cyc_last,
               swap_req, swap_seg, swap_imm, rd_vld, rd_idx,
        input  wr_err, m_vld, m_dat, m_oor, active_seg, swap_pending
    );

    modport slave (
        input  wr_en, wr_seg, wr_addr, wr_dat, cyc_we, cyc_seg, cyc_last,
               swap_req, swap_seg, swap_imm, rd_vld, rd_idx,
        output wr_err, m_vld, m_dat, m_oor, active_seg, swap_pending
    );

endinterface

// File: rtl/mod_seg_ram.sv
// Simple dual-port RAM, one write and one registered read per cycle; 1-cycle read latency.
// No backpressure; no reset on storage or read register so it maps onto block RAM.
module mod_seg_ram #(
    parameter int DW    = 16,
    parameter int AW    = 15,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/modulation_segment_buffer.sv
// Multi-segment modulation sample store with immediate/boundary swaps; 2-cycle read latency.
// Never stalls: a read is accepted every cycle; writes into the live segment are dropped and flagged.
module modulation_segment_buffer import mod_seg_pkg::*; #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 15,
    parameter int NUM_SEG = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    modulation_segment_buffer_if.slave    bus
);

    localparam int SEG_W     = seg_w(NUM_SEG);
    localparam int RAM_AW    = SEG_W + ADDR_W - 1;
    localparam int RAM_DEPTH = NUM_SEG << (ADDR_W - 1);
    localparam logic [ADDR_W-1:0] CYC_RST = ADDR_W'(cyc_last_rst(ADDR_W));

    swap_state_e         state_q, state_d;
    logic [SEG_W-1:0]    active_q, active_d;
    logic [SEG_W-1:0]    target_q, target_d;
    logic [SEG_W-1:0]    eff_seg;
    logic                boundary;
    logic                swap_ok;
    logic                wr_ok;
    logic                wr_err_q;
    logic [ADDR_W-1:0]   cyc_last_q [NUM_SEG];
    logic                s1_vld, s1_lsb, s1_oor;
    logic [2*DATA_W-1:0] rd_word;
    logic                m_vld_q, m_oor_q;
    logic [DATA_W-1:0]   m_dat_q;

    // A boundary read completes the pending swap first; a same-cycle request
    // is then judged against the segment that read actually used.
    always_comb begin
        boundary = (state_q == PENDING) && bus.rd_vld && (bus.rd_idx == '0);
        eff_seg  = boundary ? target_q : active_q;
        swap_ok  = bus.swap_req && (int'(bus.swap_seg) < NUM_SEG);
        state_d  = boundary ? IDLE : state_q;
        active_d = eff_seg;
        target_d = target_q;
        if (swap_ok) begin
            if (bus.swap_seg == eff_seg) begin
                state_d = IDLE;
            end else if (bus.swap_imm) begin
                active_d = bus.swap_seg;
                state_d  = IDLE;
            end else begin
                target_d = bus.swap_seg;
                state_d  = PENDING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            active_q <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            target_q <= target_d;
        end
    end

    assign wr_ok = bus.wr_en && (bus.wr_seg != eff_seg) && (int'(bus.wr_seg) < NUM_SEG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
            for (int i = 0; i < NUM_SEG; i++) begin
                cyc_last_q[i] <= CYC_RST;
            end
        end else begin
            wr_err_q <= bus.wr_en && !wr_ok;
            if (bus.cyc_we && (int'(bus.cyc_seg) < NUM_SEG)) begin
                cyc_last_q[bus.cyc_seg] <= bus.cyc_last;
            end
        end
    end

    mod_seg_ram #(
        .DW    (2 * DATA_W),
        .AW    (RAM_AW),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr ({bus.wr_seg, bus.wr_addr}),
        .wr_dat  (bus.wr_dat),
        .rd_addr ({eff_seg, bus.rd_idx[ADDR_W-1:1]}),
        .rd_dat  (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_lsb  <= 1'b0;
            s1_oor  <= 1'b0;
            m_vld_q <= 1'b0;
            m_oor_q <= 1'b0;
            m_dat_q <= '0;
        end else begin
            s1_vld  <= bus.rd_vld;
            s1_lsb  <= bus.rd_idx[0];
            s1_oor  <= bus.rd_idx > cyc_last_q[eff_seg];
            m_vld_q <= s1_vld;
            if (s1_vld) begin
                m_oor_q <= s1_oor;
                if (s1_oor) begin
                    m_dat_q <= '0;
                end else if (s1_lsb) begin
                    m_dat_q <= rd_word[2*DATA_W-1:DATA_W];
                end else begin
                    m_dat_q <= rd_word[DATA_W-1:0];
                end
            end
        end
    end

    assign bus.wr_err       = wr_err_q;
    assign bus.m_vld        = m_vld_q;
    assign bus.m_dat        = m_dat_q;
    assign bus.m_oor        = m_oor_q;
    assign bus.active_seg   = active_q;
    assign bus.swap_pending = (state_q == PENDING);

endmodule
